cell_bist_ctrl: RTL and testbench



---
 rtl/cell_bist_pkg.sv | 45 ++++
 rtl/cell_bist_ctrl_if.sv | 43 ++++
 rtl/cell_bist_misr.sv | 46 ++++
 rtl/cell_bist_ctrl.sv | 115 +++++++++++
 tb/tb_cell_bist_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cell_bist_pkg.sv
// Shared types, defaults and next-state helpers for the cell BIST controller.
// The helpers work on a fixed-width container so one copy serves every width.
package cell_bist_pkg;

    localparam int unsigned PAT_CNT_W = 16;
    localparam int unsigned MAX_W     = 32;

    localparam logic [3:0] DEFAULT_LFSR_TAPS = 4'b1100;
    localparam logic [3:0] DEFAULT_LFSR_SEED = 4'b0001;
    localparam logic [3:0] DEFAULT_MISR_POLY = 4'b0011;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCompare,
        StDone
    } state_e;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        if (w >= MAX_W) begin
            return '1;
        end
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Fibonacci step: shift left, feed the parity of the tapped bits into bit 0.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] v,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int unsigned w);
        logic fb;
        fb = ^(v & taps);
        return ((v << 1) | MAX_W'(fb)) & width_mask(w);
    endfunction

    // Galois step: the bit shifted out of the top folds the polynomial back in.
    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig,
                                                   input logic [MAX_W-1:0] poly,
                                                   input logic [MAX_W-1:0] data,
                                                   input int unsigned w);
        logic [MAX_W-1:0] top;
        top = sig >> (w - 1);
        return ((sig << 1) & width_mask(w)) ^ (top[0] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/cell_bist_ctrl_if.sv
// Handshake and data bundle between the BIST controller and its environment.
// CELL_BIST_RESP_MASK_EN adds the resp_mask signal.
interface cell_bist_ctrl_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned SIG_W = 4
) ();
    import cell_bist_pkg::*;

    logic                 start;
    logic                 abort;
    logic [OUT_W-1:0]     resp;
`ifdef CELL_BIST_RESP_MASK_EN
    logic [OUT_W-1:0]     resp_mask;
`endif
    logic [IN_W-1:0]      stim;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [SIG_W-1:0]     signature;
    logic [PAT_CNT_W-1:0] pat_cnt;

`ifdef CELL_BIST_RESP_MASK_EN
    modport master (
        output start, abort, resp, resp_mask,
        input  stim, busy, done, pass, signature, pat_cnt
    );
    modport slave (
        input  start, abort, resp, resp_mask,
        output stim, busy, done, pass, signature, pat_cnt
    );
`else
    modport master (
        output start, abort, resp,
        input  stim, busy, done, pass, signature, pat_cnt
    );
    modport slave (
        input  start, abort, resp,
        output stim, busy, done, pass, signature, pat_cnt
    );
`endif

endinterface

// File: rtl/cell_bist_misr.sv
// Multiple-input signature register compacting the CUT response each cycle.
// CELL_BIST_RESP_MASK_EN gates masked response bits off before compaction.
module cell_bist_misr
    import cell_bist_pkg::*;
#(
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      SIG_W     = 4,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEFAULT_MISR_POLY)
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] resp,
`ifdef CELL_BIST_RESP_MASK_EN
    input  logic [OUT_W-1:0] resp_mask,
`endif
    output logic [SIG_W-1:0] sig
);

    logic [OUT_W-1:0] absorbed;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_step;

    always_comb begin
`ifdef CELL_BIST_RESP_MASK_EN
        absorbed = resp & ~resp_mask;
`else
        absorbed = resp;
`endif
        sig_step = SIG_W'(misr_next(MAX_W'(sig_q), MAX_W'(MISR_POLY), MAX_W'(absorbed), SIG_W));
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_step;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST controller: LFSR stimulus, pattern counter and run/compare FSM around a MISR.
// CELL_BIST_RESP_MASK_EN enables response masking through the bus resp_mask signal.
module cell_bist_ctrl
    import cell_bist_pkg::*;
#(
    parameter int unsigned      IN_W       = 4,
    parameter int unsigned      OUT_W      = 4,
    parameter int unsigned      SIG_W      = 4,
    parameter int unsigned      NUM_PAT    = 15,
    parameter logic [IN_W-1:0]  LFSR_TAPS  = IN_W'(DEFAULT_LFSR_TAPS),
    parameter logic [IN_W-1:0]  LFSR_SEED  = IN_W'(DEFAULT_LFSR_SEED),
    parameter logic [SIG_W-1:0] MISR_POLY  = SIG_W'(DEFAULT_MISR_POLY),
    parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
    input logic              CK,
    input logic              RN,
    cell_bist_ctrl_if.slave  bus
);

    localparam logic [PAT_CNT_W-1:0] LAST_CNT = PAT_CNT_W'(NUM_PAT - 1);

    state_e               state_q;
    logic [IN_W-1:0]      lfsr_q;
    logic [IN_W-1:0]      lfsr_step;
    logic [PAT_CNT_W-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic                 launch;
    logic                 misr_clr;
    logic                 misr_en;
    logic [SIG_W-1:0]     misr_sig;

    // abort beats start; start is only honoured from IDLE or DONE.
    always_comb begin
        launch    = ((state_q == StIdle) || (state_q == StDone)) && bus.start && !bus.abort;
        misr_clr  = launch;
        misr_en   = (state_q == StRun) && !bus.abort;
        lfsr_step = IN_W'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(LFSR_TAPS), IN_W));
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (launch) begin
                        state_q <= StRun;
                        lfsr_q  <= LFSR_SEED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        lfsr_q <= lfsr_step;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= StCompare;
                        end
                    end
                end
                StCompare: begin
                    busy_q <= 1'b0;
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= (misr_sig == GOLDEN_SIG);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    cell_bist_misr #(
        .OUT_W     (OUT_W),
        .SIG_W     (SIG_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .CK        (CK),
        .RN        (RN),
        .clr       (misr_clr),
        .en        (misr_en),
        .resp      (bus.resp),
`ifdef CELL_BIST_RESP_MASK_EN
        .resp_mask (bus.resp_mask),
`endif
        .sig       (misr_sig)
    );

    assign bus.stim      = lfsr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_sig;
    assign bus.pat_cnt   = cnt_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Randomized bench for cell_bist_ctrl: a run-level reference model predicts every cycle.
// Build with CELL_BIST_RESP_MASK_EN to also exercise response masking.
module tb_cell_bist_ctrl;

    localparam int N     = 15;
    localparam int TAPS  = 12;
    localparam int SEED  = 1;
    localparam int POLY  = 3;
    localparam int GOLD  = 0;

    logic CK = 1'b0;
    logic RN = 1'b1;
    always #5 CK = ~CK;

    cell_bist_ctrl_if #(.IN_W(4), .OUT_W(4), .SIG_W(4)) bus ();
    cell_bist_ctrl_if #(.IN_W(4), .OUT_W(4), .SIG_W(4)) bus3 ();

    cell_bist_ctrl #(
        .IN_W(4), .OUT_W(4), .SIG_W(4), .NUM_PAT(N),
        .LFSR_TAPS(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b0011), .GOLDEN_SIG(4'b0000)
    ) dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    cell_bist_ctrl #(
        .IN_W(4), .OUT_W(4), .SIG_W(4), .NUM_PAT(3),
        .LFSR_TAPS(4'b1100), .LFSR_SEED(4'b0001), .MISR_POLY(4'b0011), .GOLDEN_SIG(4'b0000)
    ) dut3 (
        .CK  (CK),
        .RN  (RN),
        .bus (bus3)
    );

    int cut_tbl [16];
    int mask_val = 0;
    int n_vec    = 0;
    int n_err    = 0;
    bit last_pass;

    assign bus.resp  = 4'(cut_tbl[bus.stim]);
    assign bus3.resp = 4'b0001;
`ifdef CELL_BIST_RESP_MASK_EN
    assign bus.resp_mask  = 4'(mask_val);
    assign bus3.resp_mask = 4'b0000;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus register: multiply by x mod 16, shift in the parity of the tapped bits.
    function automatic int m_lfsr(input int v);
        return ((v * 2) % 16) + ($countones(v & TAPS) % 2);
    endfunction

    function automatic int m_misr(input int s, input int r);
        int n;
        n = (s * 2) % 16;
        if (s >= 8) n = n ^ POLY;
        return n ^ r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".stim"}, 32'(bus.stim), 32'(SEED));
        check_eq({tag, ".sig"},  32'(bus.signature), 32'd0);
        check_eq({tag, ".cnt"},  32'(bus.pat_cnt), 32'd0);
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ".done"}, 32'(bus.done), 32'd0);
        check_eq({tag, ".pass"}, 32'(bus.pass), 32'd0);
    endtask

    // One start from IDLE/DONE; abort_at=k asserts abort for the edge k after start (0 = none).
    task automatic run_one(input int abort_at, input bit poke_start);
        int seq [0:N];
        int sg  [0:N];
        int c;
        seq[0] = SEED;
        sg[0]  = 0;
        for (int k = 0; k < N; k++) begin
            sg[k+1]  = m_misr(sg[k], cut_tbl[seq[k]] & ~mask_val & 15);
            seq[k+1] = m_lfsr(seq[k]);
        end

        bus.start = 1'b1;
        @(posedge CK); #1;
        bus.start = 1'b0;
        check_eq("k0.stim", 32'(bus.stim), 32'(SEED));
        check_eq("k0.cnt",  32'(bus.pat_cnt), 32'd0);
        check_eq("k0.sig",  32'(bus.signature), 32'd0);
        check_eq("k0.busy", 32'(bus.busy), 32'd1);
        check_eq("k0.done", 32'(bus.done), 32'd0);
        check_eq("k0.pass", 32'(bus.pass), 32'd0);

        for (int k = 1; k <= N + 1; k++) begin
            bus.abort = (k == abort_at);
            bus.start = poke_start && ($urandom_range(0, 1) == 1);
            @(posedge CK); #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (k == abort_at) begin
                c = k - 1;
                check_eq("abort.busy", 32'(bus.busy), 32'd0);
                check_eq("abort.done", 32'(bus.done), 32'd0);
                check_eq("abort.pass", 32'(bus.pass), 32'd0);
                check_eq("abort.cnt",  32'(bus.pat_cnt), 32'(c));
                check_eq("abort.sig",  32'(bus.signature), 32'(sg[c]));
                return;
            end
            if (k <= N) begin
                check_eq("run.stim", 32'(bus.stim), 32'(seq[k]));
                check_eq("run.cnt",  32'(bus.pat_cnt), 32'(k));
                check_eq("run.sig",  32'(bus.signature), 32'(sg[k]));
                check_eq("run.busy", 32'(bus.busy), 32'd1);
                check_eq("run.done", 32'(bus.done), 32'd0);
            end else begin
                last_pass = (sg[N] == GOLD);
                check_eq("end.stim", 32'(bus.stim), 32'(seq[N]));
                check_eq("end.cnt",  32'(bus.pat_cnt), 32'(N));
                check_eq("end.sig",  32'(bus.signature), 32'(sg[N]));
                check_eq("end.busy", 32'(bus.busy), 32'd0);
                check_eq("end.done", 32'(bus.done), 32'd1);
                check_eq("end.pass", 32'(bus.pass), 32'(last_pass));
            end
        end
    endtask

    initial begin
        int exp3 [3];
        exp3[0] = 1; exp3[1] = 3; exp3[2] = 7;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        for (int i = 0; i < 16; i++) cut_tbl[i] = 0;

        #2 RN = 1'b0;
        #2 check_reset_vals("rst");
        repeat (2) @(posedge CK);
        #2 RN = 1'b1;
        @(posedge CK); #1;

        // CUT tied low: zero signature, pass
        run_one(0, 1'b0);
        check_eq("zero.pass", 32'(bus.pass), 32'd1);

        // identity CUT, spec-listed stimulus prefix checked by the model
        for (int i = 0; i < 16; i++) cut_tbl[i] = i;
        run_one(0, 1'b0);

        // start+abort together in DONE: stays in DONE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge CK); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("dsa.done", 32'(bus.done), 32'd1);
        check_eq("dsa.busy", 32'(bus.busy), 32'd0);
        check_eq("dsa.pass", 32'(bus.pass), 32'(last_pass));
        check_eq("dsa.cnt",  32'(bus.pat_cnt), 32'(N));

        // abort in 5th RUN cycle, then start+abort in IDLE, then a full run
        run_one(5, 1'b0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge CK); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_eq("isa.busy", 32'(bus.busy), 32'd0);
        check_eq("isa.cnt",  32'(bus.pat_cnt), 32'd4);
        run_one(0, 1'b1);

        // randomized CUTs, aborts and ignored start pokes
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 16; i++) cut_tbl[i] = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                run_one(int'($urandom_range(1, N + 1)), 1'b1);
            end else begin
                run_one(0, ($urandom_range(0, 1) == 1));
            end
        end

        // asynchronous reset mid-run
        bus.start = 1'b1;
        @(posedge CK); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge CK);
        #2 RN = 1'b0;
        #1 check_reset_vals("midrst");
        #2 RN = 1'b1;
        run_one(0, 1'b0);

        // NUM_PAT=3, response stuck at 0001
        bus3.start = 1'b1;
        @(posedge CK); #1;
        bus3.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CK); #1;
            check_eq("np3.sig", 32'(bus3.signature), 32'(exp3[k]));
        end
        @(posedge CK); #1;
        check_eq("np3.done", 32'(bus3.done), 32'd1);
        check_eq("np3.pass", 32'(bus3.pass), 32'd0);
        check_eq("np3.fsig", 32'(bus3.signature), 32'd7);
        check_eq("np3.cnt",  32'(bus3.pat_cnt), 32'd3);

`ifdef CELL_BIST_RESP_MASK_EN
        // faulty CUT fully masked still passes
        mask_val = 15;
        for (int i = 0; i < 16; i++) cut_tbl[i] = int'($urandom_range(1, 15));
        run_one(0, 1'b0);
        check_eq("mask.pass", 32'(bus.pass), 32'd1);
        mask_val = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
